// File: rtl/fifo_drain_pkg.sv
// Shared types for the FIFO drain engine: FSM state encoding, a default-width
// beat record, and a decode of which states hold the FIFO read request.
package fifo_drain_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    STREAM  = 3'd2,
    DISCARD = 3'd3,
    DRAIN   = 3'd4
  } drain_state_e;

  localparam int unsigned BeatDataW = 32;

  // One stream beat at the default FIFO width.
  typedef struct packed {
    logic [BeatDataW-1:0] data;
    logic                 last;
  } beat_t;

  // The read request is held for the whole packet, including the discard tail.
  function automatic logic state_holds_req(drain_state_e s);
    return (s == REQ) || (s == STREAM) || (s == DISCARD);
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry registered skid buffer. The output is driven straight from the
// head register, so an accepted input is visible on the next cycle, and input
// ready only drops when both entries are occupied.
module axis_skid_buf #(
  parameter int unsigned Width = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [Width-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [Width-1:0] head_q;
  logic [Width-1:0] tail_q;
  logic [1:0]       count_q;
  logic             push;
  logic             pop;

  assign in_ready_o  = (count_q != 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = head_q;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  // Occupancy and entry update; head is always the oldest beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= in_data_i;
          else                 tail_q <= in_data_i;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        // Simultaneous push and pop is only possible with exactly one entry
        // held, so the new beat replaces the head directly.
        2'b11: head_q <= in_data_i;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axis_fifo_drain.sv
// Read-side drain engine for the ping-pong stream FIFO. Holds the FIFO read
// request for one packet, moves beats through a skid buffer onto an AXI-Stream
// master, truncates packets longer than MaxBeats and counts finished packets.
// Optional idle-beat watchdog: define FIFO_DRAIN_TIMEOUT_EN.
module axis_fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned MaxBeats      = 256,
  parameter int unsigned CntWidth      = 16,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 fifo_empty,
  output logic                 fifo_read_req,
  input  logic [DataWidth-1:0] fifo_read_data,
  input  logic                 fifo_read_valid,
  output logic                 fifo_read_ready,
  input  logic                 fifo_read_last,
  output logic [DataWidth-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 busy,
  output logic [CntWidth-1:0]  pkt_count,
  output logic                 overlong,
  output logic                 timeout_err
);

  localparam int unsigned BeatCntW = $clog2(MaxBeats + 1);

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic                 last;
  } beat_w_t;

  drain_state_e        state_q;
  logic [BeatCntW-1:0] beat_cnt_q;
  logic                overlong_q;
  logic                inject_pend_q;
  logic [CntWidth-1:0] pkt_count_q;
  logic [CntWidth-1:0] pkt_count_d;

  beat_w_t skid_in;
  beat_w_t skid_out;
  logic    skid_in_valid;
  logic    skid_in_ready;
  logic    skid_out_valid;

  logic fwd_state;
  logic beat_acc;
  logic trunc_beat;
  logic inject_now;
  logic timeout_hit;
  logic pkt_done;

  assign fwd_state = (state_q == REQ) || (state_q == STREAM);

  // A watchdog expiry blocks acceptance in that cycle so no beat is lost
  // while the FSM abandons the packet.
  assign fifo_read_ready = ((fwd_state & skid_in_ready) | (state_q == DISCARD)) & ~timeout_hit;
  assign beat_acc        = fifo_read_valid & fifo_read_ready;
  assign trunc_beat      = fwd_state & beat_acc & ~fifo_read_last
                         & (beat_cnt_q == BeatCntW'(MaxBeats - 1));
  assign inject_now      = (state_q == DRAIN) & inject_pend_q & skid_in_ready;

  // Skid buffer input: forwarded FIFO beat, or the zero terminator beat
  // closing a packet abandoned by the watchdog.
  always_comb begin
    skid_in_valid = (fwd_state & beat_acc) | inject_now;
    skid_in.data  = fifo_read_data;
    skid_in.last  = fifo_read_last | trunc_beat;
    if (inject_now) begin
      skid_in.data = '0;
      skid_in.last = 1'b1;
    end
  end

  axis_skid_buf #(
    .Width(DataWidth + 1)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .in_data_i  (skid_in),
    .in_valid_i (skid_in_valid),
    .in_ready_o (skid_in_ready),
    .out_data_o (skid_out),
    .out_valid_o(skid_out_valid),
    .out_ready_i(m_axis_tready)
  );

  // Packet FSM with beat counter, truncation pulse and terminator request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      beat_cnt_q    <= '0;
      overlong_q    <= 1'b0;
      inject_pend_q <= 1'b0;
    end else begin
      overlong_q <= trunc_beat;
      if (inject_now) inject_pend_q <= 1'b0;
      case (state_q)
        IDLE: begin
          beat_cnt_q <= '0;
          if (enable && !fifo_empty) state_q <= REQ;
        end
        REQ, STREAM: begin
          if (timeout_hit) begin
            beat_cnt_q <= '0;
            if (state_q == REQ) begin
              state_q <= IDLE;
            end else begin
              state_q       <= DRAIN;
              inject_pend_q <= 1'b1;
            end
          end else if (beat_acc) begin
            if (fifo_read_last) begin
              state_q    <= DRAIN;
              beat_cnt_q <= '0;
            end else if (trunc_beat) begin
              state_q    <= DISCARD;
              beat_cnt_q <= '0;
            end else begin
              state_q    <= STREAM;
              beat_cnt_q <= beat_cnt_q + BeatCntW'(1);
            end
          end
        end
        DISCARD: begin
          if (timeout_hit || (beat_acc && fifo_read_last)) state_q <= DRAIN;
        end
        DRAIN: begin
          if (!skid_out_valid && !inject_pend_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pkt_done    = skid_out_valid & m_axis_tready & skid_out.last;
  assign pkt_count_d = pkt_done ? (pkt_count_q + CntWidth'(1)) : pkt_count_q;

  // Completed-packet counter; wraps naturally at the counter width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pkt_count_q <= '0;
    else       pkt_count_q <= pkt_count_d;
  end

`ifdef FIFO_DRAIN_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TimeoutCycles + 1);

  logic [WdW-1:0] wd_q;
  logic [WdW-1:0] wd_d;

  // Idle-cycle count while the read request is held; any accepted beat,
  // leaving the request states, or the expiry itself restarts it.
  always_comb begin
    if (!state_holds_req(state_q) || beat_acc || timeout_hit) wd_d = '0;
    else                                                     wd_d = wd_q + WdW'(1);
  end

  // Watchdog register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wd_q <= '0;
    else       wd_q <= wd_d;
  end

  assign timeout_hit = (wd_q == WdW'(TimeoutCycles));
  assign timeout_err = timeout_hit;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign fifo_read_req = state_holds_req(state_q);
  assign m_axis_tdata  = skid_out.data;
  assign m_axis_tlast  = skid_out.last;
  assign m_axis_tvalid = skid_out_valid;
  assign busy          = (state_q != IDLE) | skid_out_valid;
  assign pkt_count     = pkt_count_q;
  assign overlong      = overlong_q;

endmodule
